// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register and its command sequencer.
package usr_pkg;

  // Command opcodes; 101-111 are NOPs.
  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  // Shift register mode inputs.
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } usr_state_e;

  // Shift and rotate ops take a cycle count; LOAD always runs one cycle.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/usr_sequencer.sv
// Command-driven controller for the 4-bit universal shift register.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | cmd_ready high, register held; accepts the next command
// RUN   | one mode cycle per clock, remaining counts down to 1
// DONE  | one-cycle done pulse, result captured from usr_data_out
module usr_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic [1:0]       usr_mode,
  output logic [WIDTH-1:0] usr_data_in,
  input  logic [WIDTH-1:0] usr_data_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] result
);

  usr_state_e       state_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] remaining_q;
  logic             fill_q;
  logic [WIDTH-1:0] data_q;
  logic             abort_flag_q;
  logic [WIDTH-1:0] result_q;

  // Sequencer FSM with command latch, down-counter and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_LOAD;
      remaining_q  <= '0;
      fill_q       <= 1'b0;
      data_q       <= '0;
      abort_flag_q <= 1'b0;
      result_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q         <= cmd_op;
            fill_q       <= cmd_fill;
            data_q       <= cmd_data;
            abort_flag_q <= 1'b0;
            if (cmd_op == OP_LOAD) begin
              remaining_q <= CNT_W'(1);
              state_q     <= ST_RUN;
            end else if (is_shift_op(cmd_op) && (cmd_count != '0)) begin
              remaining_q <= cmd_count;
              state_q     <= ST_RUN;
            end else begin
              // count of zero and NOPs complete without touching the register
              remaining_q <= '0;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          remaining_q <= remaining_q - CNT_W'(1);
          if (abort) begin
            abort_flag_q <= 1'b1;
            state_q      <= ST_DONE;
          end else if (remaining_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          result_q <= usr_data_out;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Mode and data decode; rotate feedback from usr_data_out is combinational
  // so each RUN cycle sees the value produced by the previous edge.
  always_comb begin
    usr_mode    = MODE_HOLD;
    usr_data_in = '0;
    if (!reset && (state_q == ST_RUN) && !abort) begin
      case (op_q)
        OP_LOAD: begin
          usr_mode    = MODE_LOAD;
          usr_data_in = data_q;
        end
        OP_SHR: begin
          usr_mode       = MODE_SHR;
          usr_data_in[0] = fill_q;
        end
        OP_SHL: begin
          usr_mode       = MODE_SHL;
          usr_data_in[0] = fill_q;
        end
        OP_ROR: begin
          usr_mode       = MODE_SHR;
          usr_data_in[0] = usr_data_out[0];
        end
        OP_ROL: begin
          usr_mode       = MODE_SHL;
          usr_data_in[0] = usr_data_out[WIDTH-1];
        end
        default: begin
          usr_mode    = MODE_HOLD;
          usr_data_in = '0;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign aborted   = (state_q == ST_DONE) && abort_flag_q;
  assign result    = result_q;

endmodule

// File: tb/tb_usr_sequencer.sv
// Directed bench for usr_sequencer paired with a behavioural shift register.
module tb_usr_sequencer;
  import usr_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_count;
  logic       cmd_fill;
  logic [3:0] cmd_data;
  logic       abort;
  logic [1:0] usr_mode;
  logic [3:0] usr_data_in;
  logic [3:0] usr_data_out;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [3:0] result;

  typedef struct {
    logic [3:0] res;
    logic       ab;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  usr_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_fill(cmd_fill), .cmd_data(cmd_data),
    .abort(abort), .usr_mode(usr_mode), .usr_data_in(usr_data_in),
    .usr_data_out(usr_data_out), .busy(busy), .done(done), .aborted(aborted),
    .result(result)
  );

  // Sibling universal shift register: serial-in is taken from data_in[0].
  logic [3:0] sr_q;
  always_ff @(posedge clk) begin
    if (reset) sr_q <= 4'b0000;
    else begin
      case (usr_mode)
        2'b01:   sr_q <= {usr_data_in[0], sr_q[3:1]};
        2'b10:   sr_q <= {sr_q[2:0], usr_data_in[0]};
        2'b11:   sr_q <= usr_data_in;
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign usr_data_out = sr_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one command from the current negedge (cycle 0) through the cycle
  // after done, checking per-cycle mode and the scoreboard entry at done.
  task automatic do_cmd(input string name, input logic [2:0] op, input logic [2:0] cnt,
                        input logic fill, input logic [3:0] data, input int abort_cyc,
                        input logic [1:0] exp_mode, input int exp_n,
                        input int exp_done, input logic [3:0] exp_res, input logic exp_ab);
    exp_t e;
    bit   got_done = 1'b0;
    e.res = exp_res; e.ab = exp_ab; e.cyc = exp_done;
    sb.push_back(e);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_fill = fill; cmd_data = data;
    check({name, "_ready_c0"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      abort = (c == abort_cyc);
      #1;
      check($sformatf("%s_mode_c%0d", name, c), 32'(usr_mode),
            (c <= exp_n) ? 32'(exp_mode) : 32'(MODE_HOLD));
      if (exp_mode == MODE_LOAD && c <= exp_n)
        check($sformatf("%s_din_c%0d", name, c), 32'(usr_data_in), 32'(data));
      if (done) begin
        got_done = 1'b1;
        cur = sb.pop_front();
        check({name, "_done_cycle"}, 32'(c), 32'(cur.cyc));
        check({name, "_aborted"}, 32'(aborted), 32'(cur.ab));
        check({name, "_busy_done"}, 32'(busy), 32'd1);
        abort = 1'b0;
        @(negedge clk);
        check({name, "_result"}, 32'(result), 32'(cur.res));
        check({name, "_ready_after"}, 32'(cmd_ready), 32'd1);
        break;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    check({name, "_done_seen"}, 32'(got_done), 32'd1);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_count = 3'd0;
    cmd_fill = 1'b0; cmd_data = 4'h0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mode",    32'(usr_mode),    32'd0);
    check("rst_din",     32'(usr_data_in), 32'd0);
    check("rst_ready",   32'(cmd_ready),   32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_done",    32'(done),        32'd0);
    check("rst_aborted", 32'(aborted),     32'd0);
    check("rst_result",  32'(result),      32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: LOAD 1011
    do_cmd("load1011", OP_LOAD, 3'd0, 1'b0, 4'b1011, 0, MODE_LOAD, 1, 2, 4'b1011, 1'b0);
    // 2: SHR by 3 with fill 0
    do_cmd("shr3", OP_SHR, 3'd3, 1'b0, 4'h0, 0, MODE_SHR, 3, 4, 4'b0001, 1'b0);
    // 3: reload, rotate left 2, rotate right 4 (wrap), SHL by 0
    do_cmd("load1011b", OP_LOAD, 3'd0, 1'b0, 4'b1011, 0, MODE_LOAD, 1, 2, 4'b1011, 1'b0);
    do_cmd("rol2", OP_ROL, 3'd2, 1'b0, 4'h0, 0, MODE_SHL, 2, 3, 4'b1110, 1'b0);
    do_cmd("ror4", OP_ROR, 3'd4, 1'b0, 4'h0, 0, MODE_SHR, 4, 5, 4'b1110, 1'b0);
    do_cmd("shl0", OP_SHL, 3'd0, 1'b1, 4'h0, 0, MODE_SHL, 0, 1, 4'b1110, 1'b0);
    do_cmd("nop", 3'b110, 3'd5, 1'b1, 4'hF, 0, MODE_LOAD, 0, 1, 4'b1110, 1'b0);
    // 4: SHL 7 with fill 1, aborted in third RUN cycle
    do_cmd("load0101", OP_LOAD, 3'd0, 1'b0, 4'b0101, 0, MODE_LOAD, 1, 2, 4'b0101, 1'b0);
    do_cmd("shl7_abort", OP_SHL, 3'd7, 1'b1, 4'h0, 3, MODE_SHL, 2, 4, 4'b0111, 1'b1);
    // abort outside RUN has no effect
    abort = 1'b1;
    do_cmd("ror1_idle_abort", OP_ROR, 3'd1, 1'b0, 4'h0, 0, MODE_SHR, 1, 2, 4'b1011, 1'b0);

    // 5: reset during second RUN cycle of SHR 5
    cmd_valid = 1'b1; cmd_op = OP_SHR; cmd_count = 3'd5; cmd_fill = 1'b0;
    check("rst5_ready_c0", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rst5_mode_c1", 32'(usr_mode), 32'(MODE_SHR));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst5_mode_in_reset", 32'(usr_mode), 32'd0);
    check("rst5_ready_in_reset", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst5_done", 32'(done), 32'd0);
    check("rst5_mode", 32'(usr_mode), 32'd0);
    check("rst5_result", 32'(result), 32'd0);
    check("rst5_ready", 32'(cmd_ready), 32'd1);
    check("rst5_busy", 32'(busy), 32'd0);

    // 6: back-to-back LOADs with cmd_valid held
    e.res = 4'b1111; e.ab = 1'b0; e.cyc = 2; sb.push_back(e);
    e.res = 4'b0001; e.ab = 1'b0; e.cyc = 5; sb.push_back(e);
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 4'b1111;
    check("b2b_ready_c0", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_data = 4'b0001;
    #1;
    check("b2b_ready_c1", 32'(cmd_ready), 32'd0);
    check("b2b_mode_c1", 32'(usr_mode), 32'(MODE_LOAD));
    check("b2b_din_c1", 32'(usr_data_in), 32'hF);
    @(negedge clk);
    check("b2b_ready_c2", 32'(cmd_ready), 32'd0);
    check("b2b_done_c2", 32'(done), 32'd1);
    cur = sb.pop_front();
    check("b2b_cycle1", 32'd2, 32'(cur.cyc));
    @(negedge clk);
    check("b2b_result1", 32'(result), 32'(cur.res));
    check("b2b_ready_c3", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_mode_c4", 32'(usr_mode), 32'(MODE_LOAD));
    check("b2b_din_c4", 32'(usr_data_in), 32'h1);
    @(negedge clk);
    check("b2b_done_c5", 32'(done), 32'd1);
    cur = sb.pop_front();
    check("b2b_cycle2", 32'd5, 32'(cur.cyc));
    @(negedge clk);
    check("b2b_result2", 32'(result), 32'(cur.res));
    check("b2b_done_c6", 32'(done), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
